imem_boot_sequencer: RTL and testbench
======================================

// Module: imem_boot_sequencer
// PURPOSE
//  Boot/run controller for the byte-addressed, big-endian instruction memory. Accepts a program
//  as a word stream, writes it into instruction memory, then owns the PC and sequences
//  single-cycle execution until the PC leaves the loaded program. Replaces the hard-wired
//  memory image; sits between the host/testbench loader, the instruction memory and the PC logic.
// PARAMETERS
//  MEM_BYTES  80  instruction memory size in bytes; multiple of 4
//  CNT_W      16  width of retired-instruction counter
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   synchronous, active-high reset
//  start        in   1   request (re)load; sampled only in IDLE, HALT, ERR
//  ld_valid     in   1   loader word valid
//  ld_ready     out  1   loader word accepted when ld_valid & ld_ready
//  ld_data      in   32  instruction word; bits[31:24] go to the lowest byte address
//  ld_last      in   1   marks final word of program
//  mem_we       out  1   instruction-memory word write enable
//  mem_waddr    out  32  byte address of word write, always 4-aligned
//  mem_wdata    out  32  word to write (same packing as ld_data)
//  pc_next_in   in   32  next PC computed by datapath (PC+4 / branch / jump)
//  cpu_en       out  1   datapath enable; register file/data memory write only when 1
//  pc           out  32  current fetch address to instruction memory
//  busy         out  1   1 in LOAD or RUN
//  done         out  1   1 in HALT
//  err          out  1   1 in ERR
//  retired      out  CNT_W  instructions executed since last start, saturating
// BEHAVIOUR
//  Reset (sync): state=IDLE, wr_ptr=0, pc=0, prog_end=0, retired=0; all outputs 0.
//  States: IDLE, LOAD, RUN, HALT, ERR (encoded in 3 bits).
//  IDLE: start=1 -> LOAD next cycle; wr_ptr<=0, pc<=0, retired<=0. ld_ready=0.
//  LOAD: ld_ready=1. mem_we=ld_valid (combinational), mem_waddr=wr_ptr, mem_wdata=ld_data,
//   memory captures on same rising edge. On accept: wr_ptr<=wr_ptr+4.
//   - accept with ld_last=1 -> RUN; prog_end<=wr_ptr+4.
//   - accept with ld_last=0 at wr_ptr==MEM_BYTES-4 (memory full, no last) -> ERR; word still written.
//   - ld_valid=0: hold, no write. start ignored.
//  RUN: cpu_en=1 combinationally; each cycle is one retired instruction: retired<=retired+1
//   (saturate at all-ones). Next PC check on pc_next_in, priority order:
//   - pc_next_in[1:0]!=0 -> ERR, pc holds.
//   - pc_next_in>=prog_end (unsigned) -> HALT, pc holds (last executed address).
//   - else pc<=pc_next_in.
//   Instruction at pc executes in the cycle cpu_en=1; first instruction executes the cycle
//   after the last load accept. start ignored.
//  HALT: cpu_en=0, done=1; pc, retired, prog_end held. start -> LOAD (full reload, counters cleared).
//  ERR: cpu_en=0, err=1; start -> LOAD; otherwise sticky.
//  Reset mid-LOAD or mid-RUN: IDLE next edge; partially written memory contents are don't-care.
//  ld_ready, mem_we, cpu_en, done, err, busy are pure decodes of state (plus ld_valid for mem_we).
//  Widths: wr_ptr/prog_end compared as 32-bit unsigned; wr_ptr never exceeds MEM_BYTES.
// STRUCTURE
//  Shared package: state encoding localparams, WORD_BYTES=4, default MEM_BYTES.
//  Single module, no sub-module; FSM + wr_ptr + pc + retired counter in one always block,
//  output decode in continuous assigns.
// TESTING
//  1 reset, then start, load 20 words (lw/add sum program, ld_last on word 20) -> mem_we 20 cycles,
//    mem_waddr 0..76 step 4, RUN with prog_end=80; pc_next_in=pc+4 -> HALT after 20 RUN cycles, retired=20, pc=76.
//  2 load 21st word case: 20 words, none with ld_last -> ERR after 20th accept, err=1, cpu_en never 1.
//  3 ld_valid gaps (valid every other cycle, 3 words, last on 3rd) -> exactly 3 writes to 0,4,8; prog_end=12.
//  4 RUN, drive pc_next_in=0x6 -> ERR, pc unchanged; then start -> LOAD, pc=0, retired=0, err=0.
//  5 reset asserted mid-RUN at retired=5 -> next cycle IDLE, all outputs 0; start in RUN/LOAD ignored.
//  6 branch: pc_next_in=8 from pc=12 repeatedly -> stays RUN, retired increments each cycle, saturates at 0xFFFF.

Source files
------------

// File: rtl/imem_boot_sequencer_pkg.sv
// rtl/imem_boot_sequencer_pkg.sv - shared constants and helpers for the instruction-memory boot sequencer
//
// Purpose : state encoding, word geometry and default sizing shared by the
//           sequencer and its loader/memory interface.
// Contents: WORD_BYTES, MEM_BYTES_DEFAULT, CNT_W_DEFAULT, ST_* state codes,
//           state_t, is_word_aligned().
package imem_boot_sequencer_pkg;

    localparam int WORD_BYTES        = 4;
    localparam int MEM_BYTES_DEFAULT = 80;
    localparam int CNT_W_DEFAULT     = 16;

    typedef logic [2:0] state_t;

    // Plain 3-bit constants so the encoding stays stable for legacy tooling.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_HALT = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // A fetch address is legal only on a word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_boot_sequencer_if.sv
// rtl/imem_boot_sequencer_if.sv - loader word stream and instruction-memory write port
//
// Purpose : bundles the program-loader handshake and the word write port
//           of the instruction memory.
// Signals : ld_valid/ld_ready/ld_data/ld_last  - loader word stream
//           mem_we/mem_waddr/mem_wdata          - memory word write port
// Modports: master - host/loader side (drives words, observes memory writes)
//           slave  - sequencer side (accepts words, drives memory writes)
interface imem_boot_sequencer_if;

    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;

    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

endinterface

// File: rtl/imem_boot_sequencer.sv
// rtl/imem_boot_sequencer.sv - boot/run controller: loads a program into instruction memory, then sequences the PC
//
// Purpose : accepts a big-endian program as a word stream, writes it into the
//           instruction memory, then owns the PC and enables the datapath one
//           instruction per cycle until the PC leaves the loaded program.
// Ports   : clk        - system clock, rising edge
//           reset      - synchronous, active-high
//           start      - request (re)load; honoured in IDLE, HALT, ERR only
//           bus        - loader stream + memory write port (slave modport)
//           pc_next_in - next PC from the datapath
//           cpu_en     - datapath enable (RUN only)
//           pc         - current fetch address
//           busy       - LOAD or RUN
//           done       - HALT
//           err        - ERR
//           retired    - instructions executed since last start, saturating
module imem_boot_sequencer
    import imem_boot_sequencer_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    imem_boot_sequencer_if.slave bus,
    input  logic [31:0]          pc_next_in,
    output logic                 cpu_en,
    output logic [31:0]          pc,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     retired
);

    localparam logic [31:0] WORD_STEP = 32'(WORD_BYTES);
    // Address of the final word slot; an accept here without ld_last overflows.
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - WORD_BYTES);

    state_t             state_q,    state_d;
    logic [31:0]        wr_ptr_q,   wr_ptr_d;
    logic [31:0]        pc_q,       pc_d;
    logic [31:0]        prog_end_q, prog_end_d;
    logic [CNT_W-1:0]   retired_q,  retired_d;

    logic               accept;

    assign accept = (state_q == ST_LOAD) && bus.ld_valid;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        pc_d       = pc_q;
        prog_end_d = prog_end_q;
        retired_d  = retired_q;

        case (state_q)
            ST_IDLE, ST_HALT, ST_ERR: begin
                // Every (re)load starts from a clean slate.
                if (start) begin
                    state_d   = ST_LOAD;
                    wr_ptr_d  = '0;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + WORD_STEP;
                    if (bus.ld_last) begin
                        state_d    = ST_RUN;
                        prog_end_d = wr_ptr_q + WORD_STEP;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        // Memory is full and the program never ended.
                        state_d = ST_ERR;
                    end
                end
            end

            ST_RUN: begin
                if (retired_q != '1) begin
                    retired_d = retired_q + 1'b1;
                end
                // Misalignment wins over running off the end of the program;
                // in both cases pc keeps the last executed address.
                if (!is_word_aligned(pc_next_in)) begin
                    state_d = ST_ERR;
                end else if (pc_next_in >= prog_end_q) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_next_in;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            pc_q       <= '0;
            prog_end_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_q       <= pc_d;
            prog_end_q <= prog_end_d;
            retired_q  <= retired_d;
        end
    end

    // Memory captures the word on the same edge the loader handshake completes.
    assign bus.ld_ready  = (state_q == ST_LOAD);
    assign bus.mem_we    = accept;
    assign bus.mem_waddr = wr_ptr_q;
    assign bus.mem_wdata = bus.ld_data;

    assign cpu_en  = (state_q == ST_RUN);
    assign busy    = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done    = (state_q == ST_HALT);
    assign err     = (state_q == ST_ERR);
    assign pc      = pc_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// tb/tb_imem_boot_sequencer.sv - self-checking bench for imem_boot_sequencer
module tb_imem_boot_sequencer;

    localparam int MEM_BYTES = 80;
    localparam int CNT_W     = 8;
    localparam int RET_MAX   = (1 << CNT_W) - 1;

    localparam int ST_RUN  = 0;
    localparam int ST_HALT = 1;
    localparam int ST_ERR  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [31:0]       pc_next_in;
    logic              cpu_en;
    logic [31:0]       pc;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  retired;

    imem_boot_sequencer_if bus();

    imem_boot_sequencer #(
        .MEM_BYTES (MEM_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus.slave),
        .pc_next_in (pc_next_in),
        .cpu_en     (cpu_en),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of memory writes: pushed when a word is offered, popped when written.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  wr_q[$];
    int   n_writes    = 0;
    logic cpu_en_seen = 1'b0;

    always @(negedge clk) begin
        if (cpu_en === 1'b1) cpu_en_seen = 1'b1;
        if (bus.mem_we === 1'b1) begin
            n_writes++;
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         bus.mem_waddr, bus.mem_wdata);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("mem_waddr", bus.mem_waddr, w.addr);
                chk("mem_wdata", bus.mem_wdata, w.data);
            end
        end
    end

    // Reference model of the RUN phase.
    logic [31:0] exp_pc;
    logic [31:0] exp_end;
    int          exp_ret;
    int          exp_st;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_pc"},      pc,               exp_pc);
        chk({tag, "_retired"}, 32'(retired),     32'(exp_ret));
        chk({tag, "_busy"},    32'(busy),        32'(exp_st == ST_RUN));
        chk({tag, "_cpu_en"},  32'(cpu_en),      32'(exp_st == ST_RUN));
        chk({tag, "_done"},    32'(done),        32'(exp_st == ST_HALT));
        chk({tag, "_err"},     32'(err),         32'(exp_st == ST_ERR));
    endtask

    task automatic step(input logic [31:0] nxt, input string tag);
        pc_next_in = nxt;
        tick();
        if (exp_st == ST_RUN) begin
            if (exp_ret < RET_MAX) exp_ret++;
            if (nxt[1:0] != 2'b00)   exp_st = ST_ERR;
            else if (nxt >= exp_end) exp_st = ST_HALT;
            else                     exp_pc = nxt;
        end
        check_status(tag);
    endtask

    task automatic run_inc(input int n, input string tag);
        for (int i = 0; i < n; i++) step(exp_pc + 32'd4, tag);
    endtask

    task automatic start_load(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_ld_pc"},       pc,                 32'd0);
        chk({tag, "_ld_retired"},  32'(retired),       32'd0);
        chk({tag, "_ld_busy"},     32'(busy),          32'd1);
        chk({tag, "_ld_err"},      32'(err),           32'd0);
        chk({tag, "_ld_done"},     32'(done),          32'd0);
        chk({tag, "_ld_ready"},    32'(bus.ld_ready),  32'd1);
        n_writes = 0;
    endtask

    task automatic load_words(input int n, input bit with_last, input bit gaps, input bit hold_start);
        for (int i = 0; i < n; i++) begin
            wr_t w;
            int  t;
            w.addr       = 32'(i * 4);
            w.data       = $urandom;
            bus.ld_valid = 1'b1;
            bus.ld_data  = w.data;
            bus.ld_last  = with_last && (i == n - 1);
            start        = hold_start;
            wr_q.push_back(w);
            t = 0;
            while (bus.ld_ready !== 1'b1 && t < 8) begin
                tick();
                t++;
            end
            if (bus.ld_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL ld_ready_timeout: got ld_ready=%0b expected 1", bus.ld_ready);
            end
            tick();
            bus.ld_valid = 1'b0;
            bus.ld_last  = 1'b0;
            if (gaps && i < n - 1) tick();
        end
        start = 1'b0;
    endtask

    task automatic expect_run(input logic [31:0] prog_end);
        exp_pc  = 32'd0;
        exp_ret = 0;
        exp_end = prog_end;
        exp_st  = ST_RUN;
    endtask

    // Table vectors: optional 3-word reload (gapped), then one RUN-phase cycle.
    typedef struct {
        bit          reload;
        logic [31:0] pc_next;
        logic [31:0] exp_pc;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_err;
        int          exp_ret;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        pc_next_in   = 32'd0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'd0;
        bus.ld_last  = 1'b0;
        exp_pc = 0; exp_end = 0; exp_ret = 0; exp_st = ST_HALT;

        vecs[0] = '{1'b1, 32'd4,          32'd4, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'd8,          32'd8, 1'b1, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b0, 32'd12,         32'd8, 1'b0, 1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 32'd0,          32'd8, 1'b0, 1'b1, 1'b0, 3};
        vecs[4] = '{1'b1, 32'd4,          32'd4, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 32'h6,          32'd4, 1'b0, 1'b0, 1'b1, 2};
        vecs[6] = '{1'b0, 32'd8,          32'd4, 1'b0, 1'b0, 1'b1, 2};
        vecs[7] = '{1'b1, 32'hD,          32'd0, 1'b0, 1'b0, 1'b1, 1};
        vecs[8] = '{1'b1, 32'd0,          32'd0, 1'b1, 1'b0, 1'b0, 1};
        vecs[9] = '{1'b1 ^ 1'b1, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b1, 1'b0, 2};

        // Reset state, with ld_valid high to show no write leaks out of IDLE.
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pc",       pc,                32'd0);
        chk("rst_retired",  32'(retired),      32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_done",     32'(done),         32'd0);
        chk("rst_err",      32'(err),          32'd0);
        chk("rst_cpu_en",   32'(cpu_en),       32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_mem_we",   32'(bus.mem_we),   32'd0);
        bus.ld_valid = 1'b0;

        // 1: 20-word program, sequential execution to the end.
        start_load("t1");
        load_words(20, 1'b1, 1'b0, 1'b0);
        chk("t1_writes", 32'(n_writes), 32'd20);
        chk("t1_sb_empty", 32'(wr_q.size()), 32'd0);
        expect_run(32'd80);
        run_inc(20, "t1");
        chk("t1_final_pc",      pc,           32'd76);
        chk("t1_final_retired", 32'(retired), 32'd20);
        chk("t1_final_done",    32'(done),    32'd1);

        // 2: memory fills without ld_last.
        start_load("t2");
        cpu_en_seen = 1'b0;
        load_words(20, 1'b0, 1'b0, 1'b0);
        chk("t2_err",    32'(err),   32'd1);
        chk("t2_busy",   32'(busy),  32'd0);
        chk("t2_writes", 32'(n_writes), 32'd20);
        bus.ld_valid = 1'b1;
        tick();
        tick();
        bus.ld_valid = 1'b0;
        chk("t2_err_sticky",  32'(err),         32'd1);
        chk("t2_no_more_wr",  32'(n_writes),    32'd20);
        chk("t2_cpu_en_never", 32'(cpu_en_seen), 32'd0);

        // 3/4: gapped 3-word loads, halting, misaligned and unsigned-range exits.
        for (int v = 0; v < 10; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            if (vecs[v].reload) begin
                start_load(tag);
                load_words(3, 1'b1, 1'b1, 1'b0);
                chk({tag, "_writes"}, 32'(n_writes), 32'd3);
            end
            pc_next_in = vecs[v].pc_next;
            tick();
            chk({tag, "_pc"},      pc,           vecs[v].exp_pc);
            chk({tag, "_busy"},    32'(busy),    32'(vecs[v].exp_busy));
            chk({tag, "_cpu_en"},  32'(cpu_en),  32'(vecs[v].exp_busy));
            chk({tag, "_done"},    32'(done),    32'(vecs[v].exp_done));
            chk({tag, "_err"},     32'(err),     32'(vecs[v].exp_err));
            chk({tag, "_retired"}, 32'(retired), 32'(vecs[v].exp_ret));
        end

        // 5: start held through LOAD and RUN is ignored; reset mid-RUN.
        start_load("t5");
        load_words(8, 1'b1, 1'b0, 1'b1);
        chk("t5_writes", 32'(n_writes), 32'd8);
        expect_run(32'd32);
        start = 1'b1;
        run_inc(5, "t5");
        start = 1'b0;
        chk("t5_retired", 32'(retired), 32'd5);
        chk("t5_pc",      pc,           32'd20);
        reset = 1'b1;
        bus.ld_valid = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_pc",      pc,               32'd0);
        chk("t5_rst_retired", 32'(retired),     32'd0);
        chk("t5_rst_busy",    32'(busy),        32'd0);
        chk("t5_rst_cpu_en",  32'(cpu_en),      32'd0);
        chk("t5_rst_done",    32'(done),        32'd0);
        chk("t5_rst_err",     32'(err),         32'd0);
        chk("t5_rst_ready",   32'(bus.ld_ready), 32'd0);
        chk("t5_rst_mem_we",  32'(bus.mem_we),  32'd0);
        bus.ld_valid = 1'b0;

        // 6: backward branch loop keeps RUN alive until the counter saturates.
        start_load("t6");
        load_words(4, 1'b1, 1'b0, 1'b0);
        expect_run(32'd16);
        run_inc(3, "t6a");
        chk("t6_loop_pc", pc, 32'd12);
        for (int i = 0; i < RET_MAX + 40; i++) begin
            step((exp_pc == 32'd12) ? 32'd8 : 32'd12, "t6b");
        end
        chk("t6_sat_retired", 32'(retired), 32'(RET_MAX));
        chk("t6_still_busy",  32'(busy),    32'd1);
        chk("t6_sb_empty",    32'(wr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
